btb_controller: RTL and testbench

BTB_CONTROLLER -- requirements
Module: btb_controller

---
 rtl/btb_controller.sv | 262 ++++++++++++++++++++++++++
 tb/tb_btb_controller.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_controller.sv
// btb_controller
//
// Branch target buffer with a small recovery FSM.
//
// A 4-entry fully associative table maps a branch PC (tag) to a target and
// a 2-bit saturating direction counter. The IF/ID instruction is looked up
// combinationally. Resolved branches from EX/MEM train the table. Training
// allocates entries round-robin on a taken miss.
//
// A resolved mispredict sends the FSM from IDLE (or RECOVER) into FLUSH for
// one cycle. In that cycle the three pipeline-register flushes fire and
// pc_src selects redirect_pc. The FSM then spends one cycle in RECOVER
// before it returns to IDLE.
//
// Ports
//   clk             sole clock, rising edge
//   reset           synchronous, active-high
//   lookup_pc       PC of the IF/ID instruction
//   lookup_is_br    IF/ID instruction is a conditional branch
//   stall_in        pipeline stall; suppresses the prediction redirect
//   upd_valid       resolved branch present in EX/MEM
//   upd_pc          PC of the resolved branch
//   upd_target      computed target of the resolved branch
//   upd_taken       resolved direction
//   upd_mispredict  the earlier prediction was wrong
//   pc_src          00 PC+1, 01 pred_target, 10 redirect_pc
//   pred_hit        taken prediction for lookup_pc
//   pred_target     predicted target (0 when pred_hit is low)
//   flush_if_id, flush_id_rr, flush_rr_ex
//                   pipeline-register flushes, high only in FLUSH
//   redirect_pc     recovery PC, latched when FLUSH is entered
//   busy            FSM is not in IDLE
//
// Optional build macro BTB_STATS_EN adds two 16-bit saturating counters:
//   hit_count         counts cycles with pc_src = 01
//   mispredict_count  counts entries into FLUSH
module btb_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] lookup_pc,
  input  logic        lookup_is_br,
  input  logic        stall_in,
  input  logic        upd_valid,
  input  logic [15:0] upd_pc,
  input  logic [15:0] upd_target,
  input  logic        upd_taken,
  input  logic        upd_mispredict,
  output logic [1:0]  pc_src,
  output logic        pred_hit,
  output logic [15:0] pred_target,
  output logic        flush_if_id,
  output logic        flush_id_rr,
  output logic        flush_rr_ex,
  output logic [15:0] redirect_pc,
  output logic        busy
`ifdef BTB_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] mispredict_count
`endif
);

  localparam int unsigned ENTRIES = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  // Table state
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [15:0]        tag_q [ENTRIES];
  logic [15:0]        tag_d [ENTRIES];
  logic [15:0]        tgt_q [ENTRIES];
  logic [15:0]        tgt_d [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         ctr_d [ENTRIES];
  logic [1:0]         ptr_q, ptr_d;

  // FSM state
  logic [1:0]  state_q, state_d;
  logic [15:0] redirect_q, redirect_d;
  logic        enter_flush;

  // Lookup path
  logic        lk_match;
  logic [15:0] lk_tgt;
  logic        lk_ctr_msb;
  logic        hit_raw;
  logic        in_flush;

  // Update path
  logic        up_match;
  logic [1:0]  up_idx;

  // Lookup: an entry is allocated only on a miss, so at most one entry can
  // match a given tag. The first-match priority never resolves a real
  // conflict.
  always_comb begin
    lk_match   = 1'b0;
    lk_tgt     = '0;
    lk_ctr_msb = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!lk_match && valid_q[i] && (tag_q[i] == lookup_pc)) begin
        lk_match   = 1'b1;
        lk_tgt     = tgt_q[i];
        lk_ctr_msb = ctr_q[i][1];
      end
    end
  end

  // All observable outputs are forced to their idle values while reset is
  // high. This holds even when reset arrives mid-flush.
  always_comb begin
    hit_raw  = lk_match & lk_ctr_msb & lookup_is_br &
               (state_q == ST_IDLE) & ~reset;
    in_flush = (state_q == ST_FLUSH) & ~reset;
  end

  always_comb begin
    pred_hit    = hit_raw;
    pred_target = hit_raw ? lk_tgt : '0;
    if (in_flush) begin
      pc_src = 2'b10;
    end else if (hit_raw && !stall_in) begin
      pc_src = 2'b01;
    end else begin
      pc_src = 2'b00;
    end
    flush_if_id = in_flush;
    flush_id_rr = in_flush;
    flush_rr_ex = in_flush;
    busy        = (state_q != ST_IDLE) & ~reset;
    redirect_pc = redirect_q;
  end

  // Update tag search. It reads the pre-update table, so a lookup in the
  // same cycle also sees the old contents.
  always_comb begin
    up_match = 1'b0;
    up_idx   = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!up_match && valid_q[i] && (tag_q[i] == upd_pc)) begin
        up_match = 1'b1;
        up_idx   = 2'(i);
      end
    end
  end

  // Table training runs in every FSM state.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    ptr_d   = ptr_q;
    if (upd_valid) begin
      if (up_match) begin
        if (upd_taken) begin
          ctr_d[up_idx] = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
          tgt_d[up_idx] = upd_target;
        end else begin
          ctr_d[up_idx] = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_d[ptr_q] = 1'b1;
        tag_d[ptr_q]   = upd_pc;
        tgt_d[ptr_q]   = upd_target;
        ctr_d[ptr_q]   = 2'b10;
        ptr_d          = ptr_q + 2'd1;
      end
    end
  end

  // Recovery FSM. In FLUSH a mispredict belongs to a younger, squashed
  // instruction, so the FSM ignores it.
  always_comb begin
    state_d     = state_q;
    redirect_d  = redirect_q;
    enter_flush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (upd_valid && upd_mispredict) begin
          state_d     = ST_FLUSH;
          enter_flush = 1'b1;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (upd_valid && upd_mispredict) begin
          state_d     = ST_FLUSH;
          enter_flush = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (enter_flush) begin
      redirect_d = upd_taken ? upd_target : upd_pc + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      ptr_q      <= '0;
      state_q    <= ST_IDLE;
      redirect_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      ptr_q      <= ptr_d;
      state_q    <= state_d;
      redirect_q <= redirect_d;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= tag_d[i];
        tgt_q[i] <= tgt_d[i];
        ctr_q[i] <= ctr_d[i];
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] mispredict_count_q, mispredict_count_d;

  always_comb begin
    hit_count_d        = hit_count_q;
    mispredict_count_d = mispredict_count_q;
    if ((pc_src == 2'b01) && (hit_count_q != '1)) begin
      hit_count_d = hit_count_q + 16'd1;
    end
    if (enter_flush && (mispredict_count_q != '1)) begin
      mispredict_count_d = mispredict_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q        <= '0;
      mispredict_count_q <= '0;
    end else begin
      hit_count_q        <= hit_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  always_comb begin
    hit_count        = hit_count_q;
    mispredict_count = mispredict_count_q;
  end
`endif

endmodule

// File: tb/tb_btb_controller.sv
module tb_btb_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] lookup_pc;
  logic        lookup_is_br;
  logic        stall_in;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic [15:0] upd_target;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [1:0]  pc_src;
  logic        pred_hit;
  logic [15:0] pred_target;
  logic        flush_if_id, flush_id_rr, flush_rr_ex;
  logic [15:0] redirect_pc;
  logic        busy;
`ifdef BTB_STATS_EN
  logic [15:0] hit_count, mispredict_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  btb_controller dut (
    .clk            (clk),
    .reset          (reset),
    .lookup_pc      (lookup_pc),
    .lookup_is_br   (lookup_is_br),
    .stall_in       (stall_in),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict),
    .pc_src         (pc_src),
    .pred_hit       (pred_hit),
    .pred_target    (pred_target),
    .flush_if_id    (flush_if_id),
    .flush_id_rr    (flush_id_rr),
    .flush_rr_ex    (flush_rr_ex),
    .redirect_pc    (redirect_pc),
`ifdef BTB_STATS_EN
    .hit_count        (hit_count),
    .mispredict_count (mispredict_count),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Reference model: a list of entries plus a recovery phase
  // (0 = normal, 1 = flushing, 2 = recovering).
  bit          m_valid [4];
  logic [15:0] m_tag   [4];
  logic [15:0] m_tgt   [4];
  int          m_ctr   [4];
  int          m_ptr;
  int          m_phase;
  logic [15:0] m_redir;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
    end
    m_ptr   = 0;
    m_phase = 0;
    m_redir = '0;
  endtask

  function automatic int find(input logic [15:0] pc);
    int idx = -1;
    for (int i = 0; i < 4; i++)
      if (m_valid[i] && m_tag[i] == pc) idx = i;
    return idx;
  endfunction

  task automatic compare_all(input string ctx);
    int          idx;
    bit          hit;
    logic [15:0] tgt;
    logic [1:0]  src;
    idx = find(lookup_pc);
    hit = !reset && idx >= 0 && m_ctr[idx] >= 2 && lookup_is_br && m_phase == 0;
    tgt = hit ? m_tgt[idx] : 16'h0000;
    if (!reset && m_phase == 1) src = 2'b10;
    else if (hit && !stall_in)  src = 2'b01;
    else                        src = 2'b00;
    check({ctx, ".hit"},    32'(pred_hit),    32'(hit));
    check({ctx, ".tgt"},    32'(pred_target), 32'(tgt));
    check({ctx, ".pc_src"}, 32'(pc_src),      32'(src));
    check({ctx, ".fl_ifid"}, 32'(flush_if_id), 32'(!reset && m_phase == 1));
    check({ctx, ".fl_idrr"}, 32'(flush_id_rr), 32'(!reset && m_phase == 1));
    check({ctx, ".fl_rrex"}, 32'(flush_rr_ex), 32'(!reset && m_phase == 1));
    check({ctx, ".busy"},   32'(busy),        32'(!reset && m_phase != 0));
    check({ctx, ".redir"},  32'(redirect_pc), 32'(m_redir));
  endtask

  task automatic model_clock();
    int idx;
    bit evt;
    if (reset) begin
      model_reset();
      return;
    end
    evt = upd_valid && upd_mispredict;
    case (m_phase)
      1: m_phase = 2;
      default: begin
        if (evt) begin
          m_phase = 1;
          m_redir = upd_taken ? upd_target : 16'(upd_pc + 16'd1);
        end else begin
          m_phase = 0;
        end
      end
    endcase
    if (upd_valid) begin
      idx = find(upd_pc);
      if (idx >= 0) begin
        if (upd_taken) begin
          m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
          m_tgt[idx] = upd_target;
        end else begin
          m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_valid[m_ptr] = 1;
        m_tag[m_ptr]   = upd_pc;
        m_tgt[m_ptr]   = upd_target;
        m_ctr[m_ptr]   = 2;
        m_ptr          = (m_ptr + 1) % 4;
      end
    end
  endtask

  // Inputs change 1 time unit after the rising edge. Outputs are sampled
  // 1 time unit later, well before the next edge.
  task automatic sample(input string ctx);
    #1;
    compare_all(ctx);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic quiet();
    upd_valid      = 0;
    upd_mispredict = 0;
    upd_taken      = 0;
    stall_in       = 0;
  endtask

  task automatic upd(input logic [15:0] pc, input logic [15:0] t, input bit tk, input bit mp);
    upd_valid      = 1;
    upd_pc         = pc;
    upd_target     = t;
    upd_taken      = tk;
    upd_mispredict = mp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    lookup_pc = '0; lookup_is_br = 0; upd_pc = '0; upd_target = '0;
    quiet();
    @(posedge clk); #1;
    model_reset();
    sample("rst");
    tick();

    // Cold lookup misses
    reset = 0; lookup_pc = 16'h0010; lookup_is_br = 1;
    sample("cold");
    check("cold_hit", 32'(pred_hit), 32'd0);
    check("cold_src", 32'(pc_src),   32'd0);

    // Allocate; a lookup in the same cycle sees the old table
    upd(16'h0010, 16'h0040, 1, 0);
    sample("alloc");
    check("same_cyc_hit", 32'(pred_hit), 32'd0);
    tick();
    quiet();
    sample("pred");
    check("pred_hit", 32'(pred_hit),    32'd1);
    check("pred_tgt", 32'(pred_target), 32'h0040);
    check("pred_src", 32'(pc_src),      32'd1);
    stall_in = 1;
    sample("stall");
    check("stall_src", 32'(pc_src), 32'd0);
    stall_in = 0;

    // Counter walk: 10 -> 00, then five taken updates saturate at 11
    upd(16'h0010, 16'h0040, 0, 0); tick(); tick();
    quiet(); sample("ctr0");
    check("ctr0_hit", 32'(pred_hit), 32'd0);
    upd(16'h0010, 16'h0040, 1, 0);
    for (int i = 0; i < 5; i++) tick();
    upd(16'h0010, 16'h0040, 0, 0); tick();
    quiet(); sample("ctr_sat_dn1");
    check("sat_dn1_hit", 32'(pred_hit), 32'd1);
    upd(16'h0010, 16'h0040, 0, 0); tick();
    quiet(); sample("ctr_sat_dn2");
    check("sat_dn2_hit", 32'(pred_hit), 32'd0);

    // Round-robin wrap with five allocations
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 5; i++) begin
      upd(16'h0100 + 16'(i), 16'h0200 + 16'(i), 1, 0);
      tick();
    end
    quiet();
    lookup_pc = 16'h0100; sample("evicted");
    check("evicted_hit", 32'(pred_hit), 32'd0);
    tick();
    lookup_pc = 16'h0104; sample("fifth");
    check("fifth_tgt", 32'(pred_target), 32'h0204);
    tick();
    lookup_pc = 16'h0101; sample("second");
    check("second_hit", 32'(pred_hit), 32'd1);
    tick();

    // Mispredict, not taken; a second mispredict during FLUSH is ignored
    upd(16'h0020, 16'h0099, 0, 1); tick();
    upd(16'h0030, 16'h0077, 1, 1);
    sample("flush");
    check("flush_f",   32'(flush_if_id), 32'd1);
    check("flush_src", 32'(pc_src),      32'd2);
    check("flush_rd",  32'(redirect_pc), 32'h0021);
    tick();
    quiet(); sample("recover");
    check("rec_flush", 32'(flush_rr_ex), 32'd0);
    check("rec_busy",  32'(busy),        32'd1);
    check("rec_rd",    32'(redirect_pc), 32'h0021);
    tick();
    sample("idle");
    check("idle_busy", 32'(busy), 32'd0);
    tick();

    // Reset while in FLUSH aborts the flush
    upd(16'h0050, 16'h0123, 1, 1); tick();
    quiet(); reset = 1;
    sample("rst_in_flush");
    tick();
    reset = 0; lookup_pc = 16'h0104;
    sample("post_rst");
    check("post_rst_busy", 32'(busy),        32'd0);
    check("post_rst_fl",   32'(flush_id_rr), 32'd0);
    check("post_rst_hit",  32'(pred_hit),    32'd0);
    check("post_rst_rd",   32'(redirect_pc), 32'd0);
    tick();

    // Randomized traffic over a small PC pool to force hits and evictions
    for (int n = 0; n < 800; n++) begin
      reset          = ($urandom_range(0, 63) == 0);
      lookup_pc      = 16'h0300 + 16'($urandom_range(0, 5));
      lookup_is_br   = ($urandom_range(0, 3) != 0);
      stall_in       = ($urandom_range(0, 4) == 0);
      upd_valid      = $urandom_range(0, 1);
      upd_pc         = 16'h0300 + 16'($urandom_range(0, 5));
      upd_target     = 16'($urandom);
      upd_taken      = $urandom_range(0, 1);
      upd_mispredict = ($urandom_range(0, 3) == 0);
      sample("rnd");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
